// File: rtl/tmnt_layer_mixer.sv
// tmnt_layer_mixer: video timing generator plus two-stage fix/A/B/sprite
// priority mixer feeding the palette stage.
// Optional per-layer enable mask: define LAYER_MASK_EN to add LAYER_EN[3:0].
module tmnt_layer_mixer #(
  parameter int H_TOTAL     = 384,
  parameter int H_ACTIVE    = 320,
  parameter int HS_START    = 336,
  parameter int HS_LEN      = 32,
  parameter int V_TOTAL     = 264,
  parameter int V_ACT_START = 16,
  parameter int V_ACT_END   = 240,
  parameter int VS_LEN      = 8
) (
  input  logic       V6M,
  input  logic       RESET,
  output logic [8:0] HCNT,
  output logic [8:0] VCNT,
  input  logic [7:0] FIX_PIX,
  input  logic [7:0] A_PIX,
  input  logic [7:0] B_PIX,
  input  logic [7:0] SPR_PIX,
  input  logic       SPR_SHD,
  input  logic       PRI_MODE,
`ifdef LAYER_MASK_EN
  input  logic [3:0] LAYER_EN,
`endif
  output logic [8:0] CD,
  output logic       SHADOW,
  output logic       NCBLK,
  output logic       HSYNC,
  output logic       VSYNC
);

  localparam logic [8:0] H_LAST = 9'(H_TOTAL - 1);
  localparam logic [8:0] V_LAST = 9'(V_TOTAL - 1);
  localparam logic [8:0] H_ACT  = 9'(H_ACTIVE);
  localparam logic [8:0] HS_S   = 9'(HS_START);
  localparam logic [8:0] HS_E   = 9'(HS_START + HS_LEN);
  localparam logic [8:0] V_AS   = 9'(V_ACT_START);
  localparam logic [8:0] V_AE   = 9'(V_ACT_END);
  localparam logic [8:0] VS_E   = 9'(VS_LEN);

  // Stage-1 record: one sampled pixel plus the timing bits that travel with it.
  // en bits: 0 FIX, 1 A, 2 SPR, 3 B.
  typedef struct packed {
    logic [7:0] fix;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] spr;
    logic       shd;
    logic       pri;
    logic [3:0] en;
    logic       vis;
    logic       hs_n;
    logic       vs_n;
  } s1_t;

  localparam s1_t S1_RST = '{fix: 8'h0, a: 8'h0, b: 8'h0, spr: 8'h0,
                             shd: 1'b0, pri: 1'b0, en: 4'hf,
                             vis: 1'b0, hs_n: 1'b1, vs_n: 1'b1};

  logic [8:0] hcnt_q, hcnt_d;
  logic [8:0] vcnt_q, vcnt_d;
  s1_t        s1_q, s1_d;
  logic [8:0] cd_q, cd_d;
  logic       shadow_q, shadow_d;
  logic       ncblk_q, ncblk_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;

  logic [3:0] en_in;
`ifdef LAYER_MASK_EN
  assign en_in = LAYER_EN;
`else
  assign en_in = 4'hf;
`endif

  // Raster counters: H wraps at end of line and carries into V; V wraps at end of frame.
  always_comb begin
    hcnt_d = hcnt_q + 9'd1;
    vcnt_d = vcnt_q;
    if (hcnt_q == H_LAST) begin
      hcnt_d = 9'd0;
      vcnt_d = (vcnt_q == V_LAST) ? 9'd0 : vcnt_q + 9'd1;
    end
  end

  // Stage 1: capture the pixel belonging to the current counter position and its timing.
  always_comb begin
    s1_d      = S1_RST;
    s1_d.fix  = FIX_PIX;
    s1_d.a    = A_PIX;
    s1_d.b    = B_PIX;
    s1_d.spr  = SPR_PIX;
    s1_d.shd  = SPR_SHD;
    s1_d.pri  = PRI_MODE;
    s1_d.en   = en_in;
    s1_d.vis  = (hcnt_q < H_ACT) & (vcnt_q >= V_AS) & (vcnt_q < V_AE);
    s1_d.hs_n = ~((hcnt_q >= HS_S) & (hcnt_q < HS_E));
    s1_d.vs_n = ~(vcnt_q < VS_E);
  end

  // Stage 2: priority resolve; a shadow sprite pixel is hidden and darkens anything but FIX.
  always_comb begin
    logic fo, ao, so, spr_hit, spr_dark;
    fo       = s1_q.en[0] & (s1_q.fix[3:0] != 4'h0);
    ao       = s1_q.en[1] & (s1_q.a[3:0] != 4'h0);
    spr_hit  = s1_q.en[2] & (s1_q.spr[3:0] != 4'h0);
    so       = spr_hit & ~s1_q.shd;
    spr_dark = spr_hit & s1_q.shd;
    cd_d     = s1_q.en[3] ? {1'b0, s1_q.b} : 9'h000;
    if (fo)
      cd_d = {1'b0, s1_q.fix};
    else if (s1_q.pri) begin
      if (ao)      cd_d = {1'b0, s1_q.a};
      else if (so) cd_d = {1'b1, s1_q.spr};
    end else begin
      if (so)      cd_d = {1'b1, s1_q.spr};
      else if (ao) cd_d = {1'b0, s1_q.a};
    end
    shadow_d = ~(spr_dark & ~fo);
    ncblk_d  = s1_q.vis;
    hsync_d  = s1_q.hs_n;
    vsync_d  = s1_q.vs_n;
  end

  // State registers with synchronous reset; the whole pipe clears so a reset restarts the frame.
  always_ff @(posedge V6M) begin
    if (RESET) begin
      hcnt_q   <= 9'd0;
      vcnt_q   <= 9'd0;
      s1_q     <= S1_RST;
      cd_q     <= 9'h000;
      shadow_q <= 1'b1;
      ncblk_q  <= 1'b0;
      hsync_q  <= 1'b1;
      vsync_q  <= 1'b1;
    end else begin
      hcnt_q   <= hcnt_d;
      vcnt_q   <= vcnt_d;
      s1_q     <= s1_d;
      cd_q     <= cd_d;
      shadow_q <= shadow_d;
      ncblk_q  <= ncblk_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
    end
  end

  assign HCNT   = hcnt_q;
  assign VCNT   = vcnt_q;
  assign CD     = cd_q;
  assign SHADOW = shadow_q;
  assign NCBLK  = ncblk_q;
  assign HSYNC  = hsync_q;
  assign VSYNC  = vsync_q;

endmodule

// File: tb/tb_tmnt_layer_mixer.sv
// Bench for tmnt_layer_mixer: priority-list reference model checked every cycle,
// plus literal expectations at the interesting pixels and counter boundaries.
// A second instance with a short frame (V_TOTAL=24) exercises the frame wrap.
module tb_tmnt_layer_mixer;

  logic       V6M = 1'b0;
  logic       RESET;
  logic [8:0] HCNT, VCNT, CD;
  logic       SHADOW, NCBLK, HSYNC, VSYNC;
  logic [8:0] HCNT2, VCNT2, CD2;
  logic       SHADOW2, NCBLK2, HSYNC2, VSYNC2;
  logic [7:0] FIX_PIX, A_PIX, B_PIX, SPR_PIX;
  logic       SPR_SHD, PRI_MODE;
  logic [3:0] en_now;
`ifdef LAYER_MASK_EN
  logic [3:0] LAYER_EN;
  assign en_now = LAYER_EN;
`else
  assign en_now = 4'hf;
`endif

  always #5 V6M = ~V6M;

  tmnt_layer_mixer dut (
    .V6M(V6M), .RESET(RESET), .HCNT(HCNT), .VCNT(VCNT),
    .FIX_PIX(FIX_PIX), .A_PIX(A_PIX), .B_PIX(B_PIX), .SPR_PIX(SPR_PIX),
    .SPR_SHD(SPR_SHD), .PRI_MODE(PRI_MODE),
`ifdef LAYER_MASK_EN
    .LAYER_EN(LAYER_EN),
`endif
    .CD(CD), .SHADOW(SHADOW), .NCBLK(NCBLK), .HSYNC(HSYNC), .VSYNC(VSYNC));

  tmnt_layer_mixer #(.V_TOTAL(24), .V_ACT_START(4), .V_ACT_END(20), .VS_LEN(2)) dut_short (
    .V6M(V6M), .RESET(RESET), .HCNT(HCNT2), .VCNT(VCNT2),
    .FIX_PIX(FIX_PIX), .A_PIX(A_PIX), .B_PIX(B_PIX), .SPR_PIX(SPR_PIX),
    .SPR_SHD(SPR_SHD), .PRI_MODE(PRI_MODE),
`ifdef LAYER_MASK_EN
    .LAYER_EN(LAYER_EN),
`endif
    .CD(CD2), .SHADOW(SHADOW2), .NCBLK(NCBLK2), .HSYNC(HSYNC2), .VSYNC(VSYNC2));

  typedef struct packed {
    logic [8:0] cd;
    logic       sh;
    logic       nc;
    logic       hs;
    logic       vs;
  } out_t;

  localparam out_t RST_O = '{cd: 9'h000, sh: 1'b1, nc: 1'b0, hs: 1'b1, vs: 1'b1};

  int errors = 0;
  int checks = 0;
  int fail_prints = 0;
  bit chk_en = 1'b0;

  // Reference: walk the layers in priority order, first opaque one wins; B always opaque.
  // Layer ids: 0 FIX, 1 A, 2 SPR, 3 B.
  function automatic out_t model(input logic [7:0] f, input logic [7:0] a,
                                 input logic [7:0] b, input logic [7:0] s,
                                 input logic shd, input logic pri,
                                 input logic [3:0] en, input int h, input int v);
    out_t       o;
    int         order[4];
    logic [8:0] val[4];
    bit         opq[4];
    int         w;
    opq[0] = en[0] && (f[3:0] != 4'h0);
    opq[1] = en[1] && (a[3:0] != 4'h0);
    opq[2] = en[2] && (s[3:0] != 4'h0) && !shd;
    opq[3] = 1'b1;
    val[0] = {1'b0, f};
    val[1] = {1'b0, a};
    val[2] = {1'b1, s};
    val[3] = en[3] ? {1'b0, b} : 9'h000;
    if (pri) order = '{0, 1, 2, 3};
    else     order = '{0, 2, 1, 3};
    w = 3;
    for (int i = 3; i >= 0; i--) if (opq[order[i]]) w = order[i];
    o.cd = val[w];
    o.sh = !(en[2] && shd && (s[3:0] != 4'h0) && (w != 0));
    o.nc = (h < 320) && (v >= 16) && (v < 240);
    o.hs = !((h >= 336) && (h < 368));
    o.vs = !(v < 8);
    return o;
  endfunction

  // Model state: expected counters, and the two-cycle output alignment.
  int   mh, mv, mv2;
  out_t s1m, eom;
  always @(posedge V6M) begin
    if (RESET) begin
      mh  <= 0;
      mv  <= 0;
      mv2 <= 0;
      s1m <= RST_O;
      eom <= RST_O;
    end else begin
      eom <= s1m;
      s1m <= model(FIX_PIX, A_PIX, B_PIX, SPR_PIX, SPR_SHD, PRI_MODE, en_now, mh, mv);
      mh  <= (mh == 383) ? 0 : mh + 1;
      if (mh == 383) begin
        mv  <= (mv == 263) ? 0 : mv + 1;
        mv2 <= (mv2 == 23) ? 0 : mv2 + 1;
      end
    end
  end

  // Every-cycle compare against the model.
  always @(negedge V6M) begin
    if (chk_en) begin
      checks++;
      if (HCNT !== 9'(mh) || VCNT !== 9'(mv) || HCNT2 !== 9'(mh) || VCNT2 !== 9'(mv2) ||
          {CD, SHADOW, NCBLK, HSYNC, VSYNC} !== eom) begin
        errors++;
        if (fail_prints < 30) begin
          fail_prints++;
          $display("FAIL cycle h=%0d v=%0d: got hc=%0d vc=%0d hc2=%0d vc2=%0d cd=%h sh=%b nc=%b hs=%b vs=%b; want vc2=%0d cd=%h sh=%b nc=%b hs=%b vs=%b",
                   mh, mv, HCNT, VCNT, HCNT2, VCNT2, CD, SHADOW, NCBLK, HSYNC, VSYNC,
                   mv2, eom.cd, eom.sh, eom.nc, eom.hs, eom.vs);
        end
      end
    end
  end

  task automatic lit(input string nm, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  // Background stimulus: a rotating set of layer mixes so the model is exercised everywhere.
  task automatic drive_default();
    int idx;
    idx = (mh + mv) % 8;
    PRI_MODE = 1'(mh >> 3);
    case (idx)
      0: begin FIX_PIX = 8'h00; A_PIX = 8'h13; B_PIX = 8'h40; SPR_PIX = 8'h25; SPR_SHD = 1'b0; end
      1: begin FIX_PIX = 8'h31; A_PIX = 8'h13; B_PIX = 8'h40; SPR_PIX = 8'h25; SPR_SHD = 1'b0; end
      2: begin FIX_PIX = 8'h10; A_PIX = 8'h00; B_PIX = 8'h47; SPR_PIX = 8'h00; SPR_SHD = 1'b0; end
      3: begin FIX_PIX = 8'h00; A_PIX = 8'h10; B_PIX = 8'h41; SPR_PIX = 8'h2F; SPR_SHD = 1'b1; end
      4: begin FIX_PIX = 8'h00; A_PIX = 8'h1C; B_PIX = 8'h42; SPR_PIX = 8'h30; SPR_SHD = 1'b0; end
      5: begin FIX_PIX = 8'h02; A_PIX = 8'h00; B_PIX = 8'h43; SPR_PIX = 8'h2F; SPR_SHD = 1'b1; end
      6: begin FIX_PIX = 8'h00; A_PIX = 8'h05; B_PIX = 8'h44; SPR_PIX = 8'h2F; SPR_SHD = 1'b1; end
      default: begin FIX_PIX = 8'h00; A_PIX = 8'h00; B_PIX = 8'h45; SPR_PIX = 8'h7E; SPR_SHD = 1'b0; end
    endcase
`ifdef LAYER_MASK_EN
    case ((mh >> 4) % 8)
      2: LAYER_EN = 4'b0111;
      3: LAYER_EN = 4'b1011;
      4: LAYER_EN = 4'b1101;
      5: LAYER_EN = 4'b1110;
      6: LAYER_EN = 4'b0000;
      default: LAYER_EN = 4'b1111;
    endcase
`endif
  endtask

  task automatic step();
    @(posedge V6M);
    #1;
    drive_default();
  endtask

  task automatic step_to(input int h, input int v);
    int n;
    n = 0;
    while (!(mh == h && mv == v) && n < 30000) begin
      step();
      n++;
    end
    if (n >= 30000) begin
      errors++;
      $display("FAIL step_to timeout: got h=%0d v=%0d want h=%0d v=%0d", mh, mv, h, v);
    end
  endtask

  // Drive one hand-picked pixel, then check the result two cycles later.
  task automatic directed(input string nm, input int h, input int v,
                          input logic [7:0] f, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] s, input logic shd, input logic pri,
                          input logic [3:0] en, input logic [8:0] exp_cd, input logic exp_sh);
    step_to(h, v);
    FIX_PIX = f; A_PIX = a; B_PIX = b; SPR_PIX = s; SPR_SHD = shd; PRI_MODE = pri;
`ifdef LAYER_MASK_EN
    LAYER_EN = en;
`else
    if (en != 4'hf) $display("note: layer mask ignored in this build");
`endif
    step();
    step();
    @(negedge V6M);
    #1;
    lit({nm, " CD"}, 16'(CD), 16'(exp_cd));
    lit({nm, " SHADOW"}, 16'(SHADOW), 16'(exp_sh));
    lit({nm, " NCBLK"}, 16'(NCBLK), 16'h1);
  endtask

  initial begin
    RESET = 1'b1;
    FIX_PIX = 8'h00; A_PIX = 8'h00; B_PIX = 8'h00; SPR_PIX = 8'h00;
    SPR_SHD = 1'b0; PRI_MODE = 1'b0;
`ifdef LAYER_MASK_EN
    LAYER_EN = 4'hf;
`endif
    @(posedge V6M);
    #1;
    chk_en = 1'b1;
    @(posedge V6M);
    @(posedge V6M);
    #1;
    RESET = 1'b0;
    drive_default();
    @(negedge V6M);
    #1;
    lit("reset HCNT", 16'(HCNT), 16'd0);
    lit("reset VCNT", 16'(VCNT), 16'd0);
    lit("reset NCBLK", 16'(NCBLK), 16'd0);
    lit("reset SHADOW", 16'(SHADOW), 16'd1);
    lit("reset CD", 16'(CD), 16'h0);
    lit("reset HSYNC", 16'(HSYNC), 16'd1);

    step_to(383, 0);
    lit("line end HCNT", 16'(HCNT), 16'd383);
    step();
    lit("line wrap HCNT", 16'(HCNT), 16'd0);
    lit("line wrap VCNT", 16'(VCNT), 16'd1);

    step_to(1, 8);
    lit("vsync line 7", 16'(VSYNC), 16'd0);
    step();
    lit("vsync line 8", 16'(VSYNC), 16'd1);

    directed("mode0 spr", 5, 16, 8'h00, 8'h13, 8'h40, 8'h25, 1'b0, 1'b0, 4'hf, 9'h125, 1'b1);
    directed("mode1 a", 20, 16, 8'h00, 8'h13, 8'h40, 8'h25, 1'b0, 1'b1, 4'hf, 9'h013, 1'b1);
    directed("mode1 a clear", 30, 16, 8'h00, 8'h10, 8'h40, 8'h25, 1'b0, 1'b1, 4'hf, 9'h125, 1'b1);
    directed("shadow", 40, 16, 8'h00, 8'h13, 8'h40, 8'h2F, 1'b1, 1'b0, 4'hf, 9'h013, 1'b0);
    directed("shadow fix", 50, 16, 8'h31, 8'h13, 8'h40, 8'h2F, 1'b1, 1'b0, 4'hf, 9'h031, 1'b1);

    step_to(321, 16);
    lit("ncblk px319", 16'(NCBLK), 16'd1);
    step();
    lit("ncblk px320", 16'(NCBLK), 16'd0);
    step_to(337, 16);
    lit("hsync px335", 16'(HSYNC), 16'd1);
    step();
    lit("hsync px336", 16'(HSYNC), 16'd0);
    step_to(369, 16);
    lit("hsync px367", 16'(HSYNC), 16'd0);
    step();
    lit("hsync px368", 16'(HSYNC), 16'd1);

`ifdef LAYER_MASK_EN
    directed("mask no B", 60, 17, 8'h00, 8'h00, 8'h40, 8'h00, 1'b0, 1'b0, 4'b0111, 9'h000, 1'b1);
    directed("mask no spr", 70, 17, 8'h00, 8'h13, 8'h40, 8'h25, 1'b0, 1'b0, 4'b1011, 9'h013, 1'b1);
    directed("mask shd off", 80, 17, 8'h00, 8'h13, 8'h40, 8'h2F, 1'b1, 1'b0, 4'b1011, 9'h013, 1'b1);
`endif

    step_to(383, 23);
    lit("short frame VCNT end", 16'(VCNT2), 16'd23);
    step();
    lit("short frame wrap HCNT", 16'(HCNT2), 16'd0);
    lit("short frame wrap VCNT", 16'(VCNT2), 16'd0);
    lit("long frame VCNT 24", 16'(VCNT), 16'd24);

    step_to(100, 30);
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    lit("midframe reset HCNT", 16'(HCNT), 16'd0);
    lit("midframe reset VCNT", 16'(VCNT), 16'd0);
    lit("midframe reset NCBLK", 16'(NCBLK), 16'd0);
    lit("midframe reset CD", 16'(CD), 16'h0);
    repeat (500) step();

    @(negedge V6M);
    #1;
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tmnt_layer_mixer.md
Name: tmnt_layer_mixer

Overview:
- Pixel-rate priority mixer and video timing generator that sits directly upstream of the palette/colour stage.
- Owns the H/V counters. Samples the fix, layer A, layer B and sprite pixel streams, and resolves priority and sprite shadow.
- Drives CD[8:0], SHADOW and NCBLK, pipelined and mutually aligned, into the palette stage.

Parameters:
- H_TOTAL, 384, pixels per line (counter wraps H_TOTAL-1 -> 0)
- H_ACTIVE, 320, visible pixels per line, starting at H=0
- HS_START, 336, first H with HSYNC low
- HS_LEN, 32, HSYNC low width in pixels
- V_TOTAL, 264, lines per frame
- V_ACT_START, 16, first visible line
- V_ACT_END, 240, first non-visible line after the active area
- VS_LEN, 8, VSYNC low width, lines 0..VS_LEN-1

Ports:
- V6M  in  1  pixel clock (6 MHz enable domain)
- RESET  in  1  synchronous, active-high reset
- HCNT  out  9  current pixel counter, to the layer fetchers
- VCNT  out  9  current line counter
- FIX_PIX  in  8  fix layer index; [3:0]=0 means transparent
- A_PIX  in  8  layer A index; [3:0]=0 means transparent
- B_PIX  in  8  layer B index; always drawn as the backdrop
- SPR_PIX  in  8  sprite index; [3:0]=0 means transparent
- SPR_SHD  in  1  sprite pixel is a shadow pixel
- PRI_MODE  in  1  0: FIX>SPR>A>B, 1: FIX>A>SPR>B
- CD  out  9  palette index to the colour stage
- SHADOW  out  1  1 = full brightness, 0 = darkened
- NCBLK  out  1  1 = visible, 0 = blanked
- HSYNC  out  1  active low
- VSYNC  out  1  active low

Behaviour:
- Clocking: one clock, V6M; all state updates on its rising edge. RESET is synchronous and active-high.
- Counters:
  - HCNT increments each cycle; at H_TOTAL-1 it wraps to 0 and VCNT increments.
  - When HCNT=H_TOTAL-1 and VCNT=V_TOTAL-1, both wrap to 0 on the same edge.
- Input sampling: pixel inputs present on the cycle HCNT=n belong to pixel n. Fetchers have one cycle of their own latency budget.
- Stage 1: register all pixel inputs and PRI_MODE, plus the raw visibility bit vis = (HCNT<H_ACTIVE) & (VCNT>=V_ACT_START) & (VCNT<V_ACT_END).
- Stage 2: resolve and register outputs. CD/SHADOW/NCBLK for pixel n are valid 2 cycles after HCNT=n.
- Opaque flags: fo = FIX[3:0]!=0, ao = A[3:0]!=0, so = SPR[3:0]!=0 & ~SPR_SHD.
- Shadow: a sprite pixel with SPR_SHD=1 and [3:0]!=0 is never drawn. Resolve the remaining layers with the sprite treated as transparent, then force SHADOW=0 unless the winning layer is FIX. In all other cases SHADOW=1.
- Resolution, mode 0: fo -> {0,FIX}; else so -> {1,SPR}; else ao -> {0,A}; else {0,B}.
- Resolution, mode 1: fo -> {0,FIX}; else ao -> {0,A}; else so -> {1,SPR}; else {0,B}.
- CD[8] is 1 only for sprite pixels. CD[7:0] is the winning index unmodified.
- Blanking: NCBLK = stage-1 vis, delayed to align with CD. During blanking, CD and SHADOW still carry resolved values (the colour stage masks them).
- Sync, computed from the counters and delayed 2 cycles to align with CD:
  - HSYNC=0 for HS_START <= HCNT < HS_START+HS_LEN.
  - VSYNC=0 for VCNT < VS_LEN.
- PRI_MODE is sampled per pixel in stage 1; a change takes effect on the next sampled pixel, with no glitching within a pixel.
- Reset values: HCNT=0, VCNT=0, CD=0, SHADOW=1, NCBLK=0, HSYNC=1, VSYNC=1.
  - Pipeline registers clear to the same values.
  - Reset mid-frame restarts the frame on the next cycle.

Optional Feature:
- Macro: LAYER_MASK_EN.
- When defined:
  - Extra input LAYER_EN[3:0] (bit0 FIX, bit1 A, bit2 SPR, bit3 B), registered in stage 1.
  - A disabled FIX/A/SPR layer is treated as transparent; a disabled SPR also suppresses shadow.
  - A disabled B forces the backdrop to CD=9'h000.
- When undefined: the port is absent and all layers are always enabled.

Test Plan:
- RESET held 3 cycles then released -> HCNT=0, VCNT=0, NCBLK=0, SHADOW=1. HCNT reaches 383 and wraps to 0 with VCNT=1 after 384 cycles.
- VCNT=16, HCNT=5: FIX=0x00, SPR=0x25, A=0x13, B=0x40, PRI_MODE=0 -> two cycles later CD=0x125, SHADOW=1, NCBLK=1.
- Same pixel with PRI_MODE=1 -> CD=0x013. With A=0x10 (transparent) -> CD=0x125.
- SPR=0x2F, SPR_SHD=1, FIX=0, A=0x13 -> CD=0x013, SHADOW=0. Add FIX=0x31 -> CD=0x031, SHADOW=1.
- Counter boundaries:
  - HCNT=320 visible line -> NCBLK=0 two cycles later.
  - HCNT=336..367 -> HSYNC=0 (aligned +2).
  - VCNT=0..7 -> VSYNC=0.
  - VCNT=263, HCNT=383 -> next cycle both counters 0.
- LAYER_MASK_EN build: LAYER_EN=4'b0111, all layers transparent -> CD=0x000. LAYER_EN=4'b1011 with opaque SPR over A -> CD={0,A}.
